// File: rtl/t03_cache_pkg.sv
// Shared constants and address-split helpers for the instruction cache.
// Provides NOP_INSTR, default sizes, and idx_of()/tag_of() for word-aligned lines.
package t03_cache_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
   localparam int          DEF_NUM_LINES = 16;
   localparam int          DEF_CNT_W     = 16;

   // Line index: bits [idx_w+1:2]; returned zero-extended to 32 bits.
   function automatic logic [31:0] idx_of(input logic [31:0] a,
                                          input int unsigned idx_w);
      return (a >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Tag: bits [31:idx_w+2]; returned zero-extended to 32 bits.
   function automatic logic [31:0] tag_of(input logic [31:0] a,
                                          input int unsigned idx_w);
      return a >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/t03_instruction_cache_if.sv
// Fetch-side bundle between the request unit / bus and the instruction cache.
// master drives lookup, bus and control; slave returns next_hit, instr, counters.
interface t03_instruction_cache_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      next_pc;
   logic [31:0]      address;
   logic             read;
   logic             write;
   logic             fill;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   logic             cache_read;
   logic             advance;
   logic             flush;
   logic             next_hit;
   logic [31:0]      instr;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   modport master (
      output next_pc, address, read, write, fill, mem_ack, mem_rdata,
      output cache_read, advance, flush,
      input  next_hit, instr, hit_count, miss_count
   );

   modport slave (
      input  next_pc, address, read, write, fill, mem_ack, mem_rdata,
      input  cache_read, advance, flush,
      output next_hit, instr, hit_count, miss_count
   );
endinterface

// File: rtl/t03_sat_counter.sv
// Saturating up-counter: clears on async reset, increments on inc, sticks at all-ones.
// Ports: clk, rst, inc in; count out (CNT_W bits).
module t03_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end
endmodule

// File: rtl/t03_instruction_cache.sv
// Direct-mapped, read-only, one-word-line instruction cache with store invalidation.
// Ports: clk, rst (async high); bus (slave) carries lookup, fill bus, control and results.
module t03_instruction_cache
   import t03_cache_pkg::*;
#(
   parameter int NUM_LINES = DEF_NUM_LINES,
   parameter int CNT_W     = DEF_CNT_W
) (
   input logic                   clk,
   input logic                   rst,
   t03_instruction_cache_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
   logic [31:0]          data_arr [NUM_LINES];

   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] a_idx;
   logic [TAG_W-1:0] a_tag;
   logic             fill_fire;
   logic             inv_fire;
   logic             load;
   logic             hit_inc;

   assign pc_idx = IDX_W'(idx_of(bus.next_pc, IDX_W));
   assign pc_tag = TAG_W'(tag_of(bus.next_pc, IDX_W));
   assign a_idx  = IDX_W'(idx_of(bus.address, IDX_W));
   assign a_tag  = TAG_W'(tag_of(bus.address, IDX_W));

   assign bus.next_hit = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);

   // A store beats a coincident read; flush beats both.
   assign fill_fire = bus.mem_ack && bus.read && bus.fill
                   && !bus.write && !bus.flush;
   assign inv_fire  = bus.mem_ack && bus.write
                   && valid[a_idx] && (tag_arr[a_idx] == a_tag);

   assign load    = bus.cache_read || (bus.advance && bus.next_hit);
   assign hit_inc = bus.advance && bus.next_hit && !bus.cache_read;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid <= '0;
      else if (bus.flush)
         valid <= '0;
      else if (fill_fire)
         valid[a_idx] <= 1'b1;
      else if (inv_fire)
         valid[a_idx] <= 1'b0;
   end

   // Tag/data hold garbage until filled; valid gates their use.
   always_ff @(posedge clk) begin
      if (fill_fire) begin
         tag_arr[a_idx]  <= a_tag;
         data_arr[a_idx] <= bus.mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.instr <= NOP_INSTR;
      else if (load)
         bus.instr <= data_arr[pc_idx];
   end

   t03_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (bus.hit_count)
   );

   t03_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (fill_fire),
      .count (bus.miss_count)
   );

   // Loading on a miss returns stale or garbage data.
   a_cache_read_hit: assert property (
      @(posedge clk) disable iff (rst) bus.cache_read |-> bus.next_hit
   );
endmodule

// File: tb/tb_t03_instruction_cache.sv
// Self-checking bench for t03_instruction_cache: directed steps then random traffic.
// A word-line reference model predicts lookups, instr and counters every cycle.
module tb_t03_instruction_cache;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int NL = 16;
   localparam int SMAX = 7;
   localparam int BMAX = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   t03_instruction_cache_if #(.CNT_W(16)) bus ();
   t03_instruction_cache_if #(.CNT_W(3))  bus_s ();

   assign bus_s.next_pc    = bus.next_pc;
   assign bus_s.address    = bus.address;
   assign bus_s.read       = bus.read;
   assign bus_s.write      = bus.write;
   assign bus_s.fill       = bus.fill;
   assign bus_s.mem_ack    = bus.mem_ack;
   assign bus_s.mem_rdata  = bus.mem_rdata;
   assign bus_s.cache_read = bus.cache_read;
   assign bus_s.advance    = bus.advance;
   assign bus_s.flush      = bus.flush;

   t03_instruction_cache #(.NUM_LINES(16), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   t03_instruction_cache #(.NUM_LINES(16), .CNT_W(3)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   // Reference model: one word per line, tag = address / 64.
   bit          mvalid [NL];
   logic [31:0] mtag   [NL];
   logic [31:0] mdata  [NL];
   logic [31:0] minstr;
   int          mhits;
   int          mmiss;

   function automatic int midx(input logic [31:0] a);
      return int'((a / 4) % NL);
   endfunction

   function automatic bit mhit(input logic [31:0] a);
      return mvalid[midx(a)] && (mtag[midx(a)] == a / 64);
   endfunction

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
      minstr = NOP;
      mhits  = 0;
      mmiss  = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".hit"},   32'(bus.next_hit),   32'(mhit(bus.next_pc)));
      check({tag, ".instr"}, bus.instr,           minstr);
      check({tag, ".hcnt"},  32'(bus.hit_count),  32'(sat(mhits, BMAX)));
      check({tag, ".mcnt"},  32'(bus.miss_count), 32'(sat(mmiss, BMAX)));
      check({tag, ".hcnt3"}, 32'(bus_s.hit_count),  32'(sat(mhits, SMAX)));
      check({tag, ".mcnt3"}, 32'(bus_s.miss_count), 32'(sat(mmiss, SMAX)));
   endtask

   // Advance one clock; model uses the inputs present before the edge.
   task automatic tick();
      int          pi;
      int          ai;
      bit          h;
      logic [31:0] ni;
      pi = midx(bus.next_pc);
      ai = midx(bus.address);
      h  = mhit(bus.next_pc);
      ni = minstr;
      if (bus.cache_read || (bus.advance && h)) ni = mdata[pi];
      @(posedge clk);
      #1;
      if (rst) begin
         model_clear();
      end else begin
         minstr = ni;
         if (bus.advance && h && !bus.cache_read) mhits++;
         if (bus.flush) begin
            for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
         end else if (bus.mem_ack && bus.write) begin
            if (mvalid[ai] && mtag[ai] == bus.address / 64)
               mvalid[ai] = 1'b0;
         end else if (bus.mem_ack && bus.read && bus.fill) begin
            mvalid[ai] = 1'b1;
            mtag[ai]   = bus.address / 64;
            mdata[ai]  = bus.mem_rdata;
            mmiss++;
         end
      end
   endtask

   task automatic idle();
      bus.read = 0; bus.write = 0; bus.fill = 0; bus.mem_ack = 0;
      bus.cache_read = 0; bus.advance = 0; bus.flush = 0;
   endtask

   task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
      bus.address = a; bus.mem_rdata = d;
      bus.read = 1; bus.fill = 1; bus.mem_ack = 1;
      tick();
      idle();
   endtask

   logic [31:0] pool [8];

   initial begin
      pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h104;
      pool[3] = 32'h184; pool[4] = 32'h108; pool[5] = 32'h2000_0100;
      pool[6] = 32'h10C; pool[7] = 32'h1C0;
      idle();
      bus.next_pc = 32'h100; bus.address = 0; bus.mem_rdata = 0;
      model_clear();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.hit", 32'(bus.next_hit), 0);
      check("rst.instr", bus.instr, NOP);
      check_all("rst");
      rst = 0;

      // Cold fill and cache_read load
      do_fill(32'h100, 32'hDEAD_BEEF);
      check("fill.hit", 32'(bus.next_hit), 1);
      check("fill.mcnt", 32'(bus.miss_count), 1);
      bus.cache_read = 1;
      tick();
      idle();
      check("cread.instr", bus.instr, 32'hDEAD_BEEF);
      check_all("cread");

      // Hit path
      bus.advance = 1;
      repeat (3) tick();
      idle();
      check("adv.hcnt", 32'(bus.hit_count), 3);
      check("adv.instr", bus.instr, 32'hDEAD_BEEF);
      repeat (2) tick();
      check("hold.hcnt", 32'(bus.hit_count), 3);
      check_all("hold");

      // Conflict eviction
      do_fill(32'h140, 32'h0050_0093);
      bus.next_pc = 32'h100; #1;
      check("evict.old", 32'(bus.next_hit), 0);
      bus.next_pc = 32'h140; #1;
      check("evict.new", 32'(bus.next_hit), 1);
      check_all("evict");

      // Store invalidation
      bus.address = 32'h140; bus.write = 1; bus.mem_ack = 1;
      tick(); idle();
      check("inv.hit", 32'(bus.next_hit), 0);
      do_fill(32'h104, 32'h1111_2222);
      bus.address = 32'h180; bus.write = 1; bus.mem_ack = 1;
      tick(); idle();
      bus.next_pc = 32'h104; #1;
      check("store_other.hit", 32'(bus.next_hit), 1);
      bus.address = 32'h108; bus.read = 1; bus.write = 1;
      bus.fill = 1; bus.mem_ack = 1;
      tick(); idle();
      bus.next_pc = 32'h108; #1;
      check("rw.hit", 32'(bus.next_hit), 0);
      check("rw.mcnt", 32'(bus.miss_count), 3);
      check_all("rw");

      // Flush coincident with fill
      bus.flush = 1;
      do_fill(32'h10C, 32'h3333_4444);
      bus.next_pc = 32'h10C; #1;
      check("flush.new", 32'(bus.next_hit), 0);
      bus.next_pc = 32'h104; #1;
      check("flush.old", 32'(bus.next_hit), 0);
      check_all("flush");

      // Reset between fill request and ack
      do_fill(32'h104, 32'h5555_6666);
      bus.address = 32'h104; bus.read = 1; bus.fill = 1;
      bus.mem_rdata = 32'h7777_8888;
      rst = 1; #1;
      check("rstmid.hit", 32'(bus.next_hit), 0);
      check("rstmid.instr", bus.instr, NOP);
      check("rstmid.mcnt", 32'(bus.miss_count), 0);
      bus.mem_ack = 1;
      tick();
      rst = 0; idle(); #1;
      check("rstmid.after", 32'(bus.next_hit), 0);
      check_all("rstmid");

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bus.next_pc   = pool[$urandom_range(0, 7)];
         bus.address   = pool[$urandom_range(0, 7)];
         bus.mem_rdata = $urandom;
         bus.read      = 1'($urandom % 2);
         bus.fill      = bus.read & 1'($urandom % 4 != 0);
         bus.write     = 1'($urandom % 5 == 0);
         bus.mem_ack   = 1'($urandom % 2);
         bus.flush     = 1'($urandom % 40 == 0);
         bus.advance   = 1'($urandom % 2);
         bus.cache_read = mhit(bus.next_pc) & 1'($urandom % 4 == 0);
         #1;
         check("rnd.pre", 32'(bus.next_hit), 32'(mhit(bus.next_pc)));
         tick();
         check_all("rnd");
      end
      idle();

      // Drive the 16-bit hit counter into saturation
      do_fill(32'h100, 32'hCAFE_F00D);
      bus.next_pc = 32'h100;
      bus.advance = 1;
      for (int n = 0; n < 65540; n++) tick();
      idle();
      check("satb.hcnt", 32'(bus.hit_count), 32'hFFFF);
      check_all("satb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
